// File: rtl/riscv_run_ctrl.sv
// rtl/riscv_run_ctrl.sv - ap-style run controller for one riscv_kernel with host/core memory muxing
module riscv_run_ctrl #(
    parameter int unsigned                   AddressWidth_imem = 30,
    parameter int unsigned                   AddressWidth_dmem = 30,
    parameter int unsigned                   DataWidth         = 32,
    parameter logic [AddressWidth_dmem-1:0]  DoneAddr          = 'h3FF,
    parameter logic [31:0]                   MaxCycles         = 32'd1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_done,
    output logic                          ap_idle,
    output logic [DataWidth-1:0]          ap_return,
    output logic                          timeout,
    output logic [31:0]                   cycles,
    input  logic                          host_sel,
    input  logic                          host_we,
    input  logic [29:0]                   host_addr,
    input  logic [DataWidth-1:0]          host_wdata,
    output logic [DataWidth-1:0]          host_rdata,
    output logic                          core_rst,
    input  logic [AddressWidth_imem-1:0]  core_imem_address0,
    input  logic                          core_imem_ce0,
    input  logic [AddressWidth_dmem-1:0]  core_dmem_address0,
    input  logic                          core_dmem_ce0,
    input  logic                          core_dmem_we0,
    input  logic [DataWidth-1:0]          core_dmem_d0,
    output logic [DataWidth-1:0]          core_imem_q0,
    output logic [DataWidth-1:0]          core_dmem_q0,
    output logic [AddressWidth_imem-1:0]  imem_address0,
    output logic                          imem_ce0,
    output logic                          imem_we0,
    output logic [DataWidth-1:0]          imem_d0,
    input  logic [DataWidth-1:0]          imem_q0,
    output logic [AddressWidth_dmem-1:0]  dmem_address0,
    output logic                          dmem_ce0,
    output logic                          dmem_we0,
    output logic [DataWidth-1:0]          dmem_d0,
    input  logic [DataWidth-1:0]          dmem_q0
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          cycles_q, cycles_d;
    logic                 timeout_q, timeout_d;
    logic [DataWidth-1:0] ret_q, ret_d;
    logic                 host_sel_q;
    logic                 done_store;
    logic                 watchdog_hit;

    assign done_store   = core_dmem_ce0 & core_dmem_we0 & (core_dmem_address0 == DoneAddr);
    assign watchdog_hit = (MaxCycles != 32'd0) && (cycles_q == MaxCycles - 32'd1);

    // State and run-result registers; reset lands in IDLE so core_rst rises asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cycles_q   <= 32'd0;
            timeout_q  <= 1'b0;
            ret_q      <= '0;
            host_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
            ret_q      <= ret_d;
            host_sel_q <= host_sel;
        end
    end

    // Next-state logic: done store beats the watchdog when both land on the same cycle
    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        ret_d     = ret_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) state_d = S_START;
            end
            S_START: begin
                cycles_d  = 32'd0;
                timeout_d = 1'b0;
                ret_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
                if (done_store) begin
                    ret_d     = core_dmem_d0;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (watchdog_hit) begin
                    ret_d     = '1;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory ownership: core only while RUN, host in every other state
    always_comb begin
        imem_address0 = AddressWidth_imem'(host_addr);
        imem_ce0      = ~host_sel;
        imem_we0      = ~host_sel & host_we;
        imem_d0       = host_wdata;
        dmem_address0 = AddressWidth_dmem'(host_addr);
        dmem_ce0      = host_sel;
        dmem_we0      = host_sel & host_we;
        dmem_d0       = host_wdata;
        if (state_q == S_RUN) begin
            imem_address0 = core_imem_address0;
            imem_ce0      = core_imem_ce0;
            imem_we0      = 1'b0;
            imem_d0       = '0;
            dmem_address0 = core_dmem_address0;
            dmem_ce0      = core_dmem_ce0;
            dmem_we0      = core_dmem_we0;
            dmem_d0       = core_dmem_d0;
        end
    end

    // Read data follows the memory selected when the address was presented
    assign host_rdata   = host_sel_q ? dmem_q0 : imem_q0;
    assign core_imem_q0 = imem_q0;
    assign core_dmem_q0 = dmem_q0;

    assign core_rst  = (state_q != S_RUN);
    assign ap_idle   = (state_q == S_IDLE);
    assign ap_ready  = (state_q == S_START);
    assign ap_done   = (state_q == S_DONE);
    assign ap_return = ret_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;

endmodule
